// File: rtl/core_ctrl_pkg.sv
// Shared constants for the multi-cycle core control path: opcodes, FSM states,
// ALU operand mux encodings and the aluop code shared with alu_control.
package core_ctrl_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAddr  = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StExecI    = 4'd7,
      StAluWb    = 4'd8,
      StBranch   = 4'd9,
      StHalt     = 4'd10
   } state_t;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

endpackage

// File: rtl/main_control_fsm.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback and
// drives all datapath strobes, mux selects and the aluop/force_add pair.
module main_control_fsm
   import core_ctrl_pkg::*;
#(
   parameter int unsigned OPC_W = 7
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [OPC_W-1:0] i_opcode,
   input  logic             i_mem_ready,
   output logic             o_pc_write,
   output logic             o_pc_write_cond,
   output logic             o_ir_write,
   output logic             o_iord,
   output logic             o_mem_read,
   output logic             o_mem_write,
   output logic             o_reg_write,
   output logic             o_mem_to_reg,
   output logic [1:0]       o_alu_src_a,
   output logic [1:0]       o_alu_src_b,
   output logic             o_pc_source,
   output logic [1:0]       o_aluop,
   output logic             o_force_add,
   output logic             o_instr_retired,
   output logic             o_halted
);

   state_t r_state;
   state_t w_state_next;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= StFetch;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = StFetch;
      unique case (r_state)
         StFetch:    w_state_next = i_mem_ready ? StDecode : StFetch;
         StDecode: begin
            if (i_opcode == OPC_LOAD || i_opcode == OPC_STORE) begin
               w_state_next = StMemAddr;
            end else if (i_opcode == OPC_OP) begin
               w_state_next = StExecR;
            end else if (i_opcode == OPC_OP_IMM) begin
               w_state_next = StExecI;
            end else if (i_opcode == OPC_BRANCH) begin
               w_state_next = StBranch;
            end else begin
               w_state_next = StHalt;
            end
         end
         StMemAddr:  w_state_next = (i_opcode == OPC_LOAD) ? StMemRead : StMemWrite;
         StMemRead:  w_state_next = i_mem_ready ? StMemWb : StMemRead;
         StMemWb:    w_state_next = StFetch;
         StMemWrite: w_state_next = i_mem_ready ? StFetch : StMemWrite;
         StExecR:    w_state_next = StAluWb;
         StExecI:    w_state_next = StAluWb;
         StAluWb:    w_state_next = StFetch;
         StBranch:   w_state_next = StFetch;
         StHalt:     w_state_next = StHalt;
         default:    w_state_next = StFetch;
      endcase
   end

   // Outputs are forced low while reset is held, independent of the state register.
   always_comb begin
      o_pc_write      = 1'b0;
      o_pc_write_cond = 1'b0;
      o_ir_write      = 1'b0;
      o_iord          = 1'b0;
      o_mem_read      = 1'b0;
      o_mem_write     = 1'b0;
      o_reg_write     = 1'b0;
      o_mem_to_reg    = 1'b0;
      o_alu_src_a     = SRCA_PC;
      o_alu_src_b     = SRCB_RS2;
      o_pc_source     = 1'b0;
      o_aluop         = ALUOP_ADD;
      o_force_add     = 1'b0;
      o_instr_retired = 1'b0;
      o_halted        = 1'b0;
      if (i_rst_n) begin
         unique case (r_state)
            StFetch: begin
               o_mem_read  = 1'b1;
               o_alu_src_a = SRCA_PC;
               o_alu_src_b = SRCB_FOUR;
               o_aluop     = ALUOP_ADD;
               o_force_add = 1'b1;
               o_ir_write  = i_mem_ready;
               o_pc_write  = i_mem_ready;
            end
            StDecode: begin
               o_alu_src_a = SRCA_OLDPC;
               o_alu_src_b = SRCB_IMM;
               o_force_add = 1'b1;
            end
            StMemAddr: begin
               o_alu_src_a = SRCA_RS1;
               o_alu_src_b = SRCB_IMM;
               o_force_add = 1'b1;
            end
            StMemRead: begin
               o_mem_read = 1'b1;
               o_iord     = 1'b1;
            end
            StMemWb: begin
               o_reg_write     = 1'b1;
               o_mem_to_reg    = 1'b1;
               o_instr_retired = 1'b1;
            end
            StMemWrite: begin
               o_mem_write     = 1'b1;
               o_iord          = 1'b1;
               o_instr_retired = i_mem_ready;
            end
            StExecR: begin
               o_alu_src_a = SRCA_RS1;
               o_alu_src_b = SRCB_RS2;
               o_aluop     = ALUOP_RTYPE;
            end
            StExecI: begin
               o_alu_src_a = SRCA_RS1;
               o_alu_src_b = SRCB_IMM;
               o_aluop     = ALUOP_ADD;
            end
            StAluWb: begin
               o_reg_write     = 1'b1;
               o_instr_retired = 1'b1;
            end
            StBranch: begin
               o_alu_src_a     = SRCA_RS1;
               o_alu_src_b     = SRCB_RS2;
               o_aluop         = ALUOP_SUB;
               o_pc_write_cond = 1'b1;
               o_pc_source     = 1'b1;
               o_instr_retired = 1'b1;
            end
            StHalt:  o_halted = 1'b1;
            default: o_halted = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: per-cycle expected output vectors are queued
// as stimulus is applied and popped/compared at the following negative clock edge.
module tb_main_control_fsm;

   localparam int S_F   = 0;
   localparam int S_D   = 1;
   localparam int S_MA  = 2;
   localparam int S_MR  = 3;
   localparam int S_MWB = 4;
   localparam int S_MW  = 5;
   localparam int S_ER  = 6;
   localparam int S_EI  = 7;
   localparam int S_AWB = 8;
   localparam int S_BR  = 9;
   localparam int S_H   = 10;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   logic       clk;
   logic       rst_n;
   logic [6:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write;
   logic       reg_write, mem_to_reg, pc_source, force_add, instr_retired, halted;
   logic [1:0] alu_src_a, alu_src_b, aluop;
   logic [18:0] obs;

   int n_tests = 0;
   int n_fail  = 0;
   logic [18:0] exp_q[$];
   string       tag_q[$];

   main_control_fsm #(.OPC_W(7)) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_opcode        (opcode),
      .i_mem_ready     (mem_ready),
      .o_pc_write      (pc_write),
      .o_pc_write_cond (pc_write_cond),
      .o_ir_write      (ir_write),
      .o_iord          (iord),
      .o_mem_read      (mem_read),
      .o_mem_write     (mem_write),
      .o_reg_write     (reg_write),
      .o_mem_to_reg    (mem_to_reg),
      .o_alu_src_a     (alu_src_a),
      .o_alu_src_b     (alu_src_b),
      .o_pc_source     (pc_source),
      .o_aluop         (aluop),
      .o_force_add     (force_add),
      .o_instr_retired (instr_retired),
      .o_halted        (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign obs = {pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, reg_write,
                 mem_to_reg, alu_src_a, alu_src_b, pc_source, aluop, force_add,
                 instr_retired, halted};

   function automatic logic [18:0] exp_out(input int st, input logic mr);
      logic pcw, pcc, irw, io, mrd, mwr, rw, m2r, pcs, fa, ret, hlt;
      logic [1:0] sa, sb, aop;
      {pcw, pcc, irw, io, mrd, mwr, rw, m2r, pcs, fa, ret, hlt} = '0;
      sa = 2'b00; sb = 2'b00; aop = 2'b00;
      case (st)
         S_F:   begin mrd = 1; sb = 2'b01; fa = 1; irw = mr; pcw = mr; end
         S_D:   begin sa = 2'b01; sb = 2'b10; fa = 1; end
         S_MA:  begin sa = 2'b10; sb = 2'b10; fa = 1; end
         S_MR:  begin mrd = 1; io = 1; end
         S_MWB: begin rw = 1; m2r = 1; ret = 1; end
         S_MW:  begin mwr = 1; io = 1; ret = mr; end
         S_ER:  begin sa = 2'b10; sb = 2'b00; aop = 2'b10; end
         S_EI:  begin sa = 2'b10; sb = 2'b10; end
         S_AWB: begin rw = 1; ret = 1; end
         S_BR:  begin sa = 2'b10; aop = 2'b01; pcc = 1; pcs = 1; ret = 1; end
         S_H:   hlt = 1;
         default: ;
      endcase
      return {pcw, pcc, irw, io, mrd, mwr, rw, m2r, sa, sb, pcs, aop, fa, ret, hlt};
   endfunction

   task automatic check_outputs();
      logic [18:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_tests++;
      assert (obs === e) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", t, obs, e);
      end
      n_tests++;
      assert (!(mem_read && mem_write)) else begin
         n_fail++;
         $error("FAIL %s_rw_excl: observed rd=%b wr=%b expected not both", t, mem_read, mem_write);
      end
      n_tests++;
      assert (!(pc_write && pc_write_cond)) else begin
         n_fail++;
         $error("FAIL %s_pc_excl: observed pcw=%b pcc=%b expected not both", t, pc_write,
                pc_write_cond);
      end
   endtask

   // One clock cycle: drive inputs, queue the expectation, compare mid-cycle.
   task automatic step(input logic rst, input logic [6:0] op, input logic mr, input int st,
                       input string tag);
      rst_n     = rst;
      opcode    = op;
      mem_ready = mr;
      exp_q.push_back(rst ? exp_out(st, mr) : 19'd0);
      tag_q.push_back(tag);
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; opcode = '0; mem_ready = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) step(1'b0, OP_R, 1'b1, S_F, "reset");
      step(1'b1, OP_R, 1'b1, S_F,   "r_fetch");
      step(1'b1, OP_R, 1'b1, S_D,   "r_decode");
      step(1'b1, OP_R, 1'b1, S_ER,  "r_exec");
      step(1'b1, OP_R, 1'b1, S_AWB, "r_wb");
      step(1'b1, OP_LW, 1'b1, S_F,   "lw_fetch");
      step(1'b1, OP_LW, 1'b1, S_D,   "lw_decode");
      step(1'b1, OP_LW, 1'b1, S_MA,  "lw_addr");
      step(1'b1, OP_LW, 1'b0, S_MR,  "lw_read_w0");
      step(1'b1, OP_LW, 1'b0, S_MR,  "lw_read_w1");
      step(1'b1, OP_LW, 1'b1, S_MR,  "lw_read");
      step(1'b1, OP_LW, 1'b1, S_MWB, "lw_wb");
      step(1'b1, OP_SW, 1'b1, S_F,  "sw_fetch");
      step(1'b1, OP_SW, 1'b1, S_D,  "sw_decode");
      step(1'b1, OP_SW, 1'b1, S_MA, "sw_addr");
      step(1'b1, OP_SW, 1'b1, S_MW, "sw_write");
      step(1'b1, OP_BEQ, 1'b1, S_F,  "beq_fetch");
      step(1'b1, OP_BEQ, 1'b1, S_D,  "beq_decode");
      step(1'b1, OP_BEQ, 1'b1, S_BR, "beq_branch");
      for (int i = 0; i < 4; i++) step(1'b1, OP_I, 1'b0, S_F, "fetch_stall");
      step(1'b1, OP_I, 1'b1, S_F,   "i_fetch");
      step(1'b1, OP_I, 1'b1, S_D,   "i_decode");
      step(1'b1, OP_I, 1'b1, S_EI,  "i_exec");
      step(1'b1, OP_I, 1'b1, S_AWB, "i_wb");
      step(1'b1, OP_SW, 1'b1, S_F,  "sw2_fetch");
      step(1'b1, OP_SW, 1'b1, S_D,  "sw2_decode");
      step(1'b1, OP_SW, 1'b1, S_MA, "sw2_addr");
      step(1'b1, OP_SW, 1'b0, S_MW, "sw2_write_wait");
      step(1'b1, OP_SW, 1'b1, S_MW, "sw2_write");
      step(1'b1, OP_BAD, 1'b1, S_F, "bad_fetch");
      step(1'b1, OP_BAD, 1'b1, S_D, "bad_decode");
      for (int i = 0; i < 10; i++) step(1'b1, OP_R, logic'(i % 2), S_H, "halt");
      step(1'b0, OP_R, 1'b1, S_F,  "halt_reset");
      step(1'b1, OP_LW, 1'b1, S_F, "post_halt_fetch");
      step(1'b1, OP_LW, 1'b1, S_D, "abort_decode");
      step(1'b0, OP_LW, 1'b1, S_F, "abort_reset");
      step(1'b1, OP_LW, 1'b1, S_F, "abort_fetch");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/main_control_fsm.md
Name: main_control_fsm

Overview:
Multi-cycle main control unit for the RV32I-subset core. It is the upstream end of the aluop interface: it sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath strobe and mux select, and it supplies aluop and force_add to alu_control. It stalls on a memory ready handshake and halts permanently on an unsupported opcode.

Parameters:
- OPC_W, 7, opcode field width.
- None else. Opcodes, state codes and mux encodings are constants in core_ctrl_pkg.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous active-low reset.
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- mem_ready  in  1  memory completes the current read or write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (BEQ).
- ir_write  out  1  latch IR and old_pc register.
- iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write.
- mem_to_reg  out  1  0 = ALUOut to register file, 1 = MDR to register file.
- alu_src_a  out  2  00 = PC, 01 = old_pc, 10 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
- pc_source  out  1  0 = ALU result, 1 = ALUOut.
- aluop  out  2  to alu_control: 00 = I/add, 01 = sub, 10 = R-type.
- force_add  out  1  datapath feeds funct3 = 000 to alu_control.
- instr_retired  out  1  one-cycle pulse on an instruction's final cycle.
- halted  out  1  illegal opcode seen; sticky until reset.

Behaviour:
- State register only; all outputs are Moore, decoded from state and gated by mem_ready where stated.
- While rst_n = 0: all outputs are 0.
- At the first clock edge with rst_n = 0: state goes to FETCH.
- Reset mid-instruction aborts it with no further strobes, even in HALT.
- Unlisted outputs are 0 in each state.
- FETCH:
  - Outputs: mem_read = 1, iord = 0, alu_src_a = 00, alu_src_b = 01, aluop = 00, force_add = 1, pc_source = 0.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE:
  - Outputs: alu_src_a = 01, alu_src_b = 10, aluop = 00, force_add = 1 (branch target into ALUOut).
  - Transitions by opcode:
    - 0000011 (LW) or 0100011 (SW) go to MEM_ADDR.
    - 0110011 goes to EXEC_R.
    - 0010011 goes to EXEC_I.
    - 1100011 goes to BRANCH.
    - Any other opcode goes to HALT.
- MEM_ADDR:
  - Outputs: alu_src_a = 10, alu_src_b = 10, aluop = 00, force_add = 1.
  - LW goes to MEM_READ; SW goes to MEM_WRITE.
- MEM_READ:
  - Outputs: mem_read = 1, iord = 1.
  - Waits on mem_ready; then goes to MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, instr_retired = 1; goes to FETCH.
- MEM_WRITE:
  - Outputs: mem_write = 1, iord = 1; instr_retired = mem_ready.
  - Waits on mem_ready; then goes to FETCH.
- EXEC_R: alu_src_a = 10, alu_src_b = 00, aluop = 10; goes to ALU_WB.
- EXEC_I: alu_src_a = 10, alu_src_b = 10, aluop = 00, force_add = 0; goes to ALU_WB.
- ALU_WB: reg_write = 1, mem_to_reg = 0, instr_retired = 1; goes to FETCH.
- BRANCH:
  - Outputs: alu_src_a = 10, alu_src_b = 00, aluop = 01, pc_write_cond = 1, pc_source = 1, instr_retired = 1.
  - Goes to FETCH.
- HALT: halted = 1, all strobes 0; leaves only on reset.
- Latency with mem_ready always 1:
  - R/I-type: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
  - Each memory wait cycle adds 1.
- mem_read and mem_write are never both 1.
- pc_write and pc_write_cond are never both 1.
- Unreachable state encodings recover to FETCH on the next edge.

Decomposition:
- core_ctrl_pkg holds:
  - opcode constants;
  - the state_t enum;
  - alu_src_a/alu_src_b encodings;
  - aluop encodings, shared with alu_control.
- One module with two processes (next-state and output decode). No sub-module is needed.

Test Plan:
- Reset check: hold rst_n = 0 for 3 cycles, then release with mem_ready = 1.
  - All outputs are 0 during reset.
  - The first cycle after release is FETCH with mem_read = 1, ir_write = 1, pc_write = 1.
- R-type, opcode 0110011, mem_ready = 1:
  - States run FETCH, DECODE, EXEC_R, ALU_WB.
  - aluop = 10 in EXEC_R; reg_write and instr_retired are 1 in cycle 4 only.
- LW, opcode 0000011, with mem_ready low for 2 cycles in MEM_READ:
  - Takes 7 cycles.
  - iord = 1 throughout MEM_READ; mem_to_reg = 1 and reg_write = 1 in MEM_WB.
- SW, then BEQ:
  - SW shows mem_write = 1 for 1 cycle and instr_retired in MEM_WRITE.
  - BEQ shows aluop = 01, pc_write_cond = 1, pc_source = 1 in cycle 3.
- FETCH stall with mem_ready = 0 for 4 cycles:
  - State holds FETCH.
  - ir_write and pc_write stay 0 until mem_ready = 1.
- Illegal opcode 1111111 in DECODE:
  - Goes to HALT; halted = 1 and stays 1 for 10 cycles.
  - A reset pulse returns the FSM to FETCH with halted = 0.
